// File: rtl/sigan_multi.sv
// sigan_multi: multi-channel signature analyser.
// Each of CHANNELS data streams is compressed into a WIDTH-bit LFSR signature
// over a window that is opened by a start sample and closed by a stop sample.
// All channels share the window.
// Optional feature macro: SIGAN_HOLD_EN adds a hold_i port. When hold_i is high
// on the DONE entry, that capture is suppressed.
// Capture timing: the capture registers load on the same edge that moves the
// FSM into DONE. valid_o is therefore high during the DONE entry cycle.
// Counter overflow: count_ovf is set when a sample arrives while the window
// counter is already all-ones. The counter saturates and never wraps.
module sigan_multi #(
  parameter int               CHANNELS = 4,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = 16'h8940,
  parameter int               CNT_W    = 24
) (
  input  logic                      clk,
  input  logic                      reset_h,
  input  logic                      sample_en_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [CHANNELS-1:0]       data_i,
  input  logic                      arm_i,
  input  logic                      cont_i,
`ifdef SIGAN_HOLD_EN
  input  logic                      hold_i,
`endif
  output logic [CHANNELS*WIDTH-1:0] signature_o,
  output logic [CNT_W-1:0]          bit_count_o,
  output logic                      count_ovf_o,
  output logic [CHANNELS-1:0]       unstable_o,
  output logic                      valid_o,
  output logic                      gate_o
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_e;

  state_e                            state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              ovf_q, ovf_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    sig_q;
  logic [CNT_W-1:0]                  bcnt_q;
  logic                              covf_q;
  logic [CHANNELS-1:0]               unst_q, unst_d;
  logic                              valid_q;
  logic                              prev_valid_q;
  logic                              load;
  logic                              shift;
  logic                              capture;

  // Window control: next state, plus the clear/shift strobes for the datapath.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm_i) state_d = ARMED;
      end
      ARMED: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (sample_en_i && start_i) begin
          load = 1'b1;
          if (stop_i) begin
            state_d = DONE;            // zero-length window
          end else begin
            state_d = RUN;
            shift   = 1'b1;            // start sample is the first bit shifted
          end
        end
      end
      RUN: begin
        if (sample_en_i) begin
          if (stop_i) state_d = DONE;  // stop sample is not shifted
          else        shift   = 1'b1;
        end
      end
      DONE: begin
        if (cont_i)      state_d = ARMED;
        else if (!arm_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture happens once, on the edge that enters DONE, unless held off.
`ifdef SIGAN_HOLD_EN
  assign capture = (state_d == DONE) && (state_q != DONE) && !hold_i;
`else
  assign capture = (state_d == DONE) && (state_q != DONE);
`endif

  // LFSR and window-counter next state; a window start clears both before the first shift.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (load) begin
      lfsr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
    if (shift) begin
      for (int n = 0; n < CHANNELS; n++) begin
        lfsr_d[n] = {lfsr_d[n][WIDTH-2:0], data_i[n] ^ (^(lfsr_d[n] & POLY))};
      end
      if (&cnt_d) ovf_d = 1'b1;
      else        cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // Stability: compare each new signature against the last one captured.
  always_comb begin
    unst_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      unst_d[n] = prev_valid_q & (lfsr_d[n] != sig_q[n]);
    end
  end

  // FSM state, LFSRs and window counter.
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture registers and the one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      // NOTE: the signature store is a few registers, not a RAM, so it is reset along with everything else.
      sig_q        <= '0;
      bcnt_q       <= '0;
      covf_q       <= 1'b0;
      unst_q       <= '0;
      valid_q      <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        sig_q        <= lfsr_d;
        bcnt_q       <= cnt_d;
        covf_q       <= ovf_d;
        unst_q       <= unst_d;
        prev_valid_q <= 1'b1;
      end
    end
  end

  assign signature_o = sig_q;
  assign bit_count_o = bcnt_q;
  assign count_ovf_o = covf_q;
  assign unstable_o  = unst_q;
  assign valid_o     = valid_q;
  assign gate_o      = (state_q == RUN);

endmodule

// File: tb/tb_sigan_multi.sv
// Directed bench for sigan_multi: a 1-channel default instance and a
// 4-channel instance with a 4-bit window counter share all control inputs;
// the 1-channel instance sees channel 0 of the 4-channel data.
module tb_sigan_multi;

  logic        clk = 1'b0;
  logic        reset_h, sample_en, start, stop, arm, cont, hold;
  logic [3:0]  data4;

  logic [15:0] sig1;
  logic [23:0] bcnt1;
  logic        ovf1, unst1, valid1, gate1;
  logic [63:0] sig4;
  logic [3:0]  bcnt4;
  logic        ovf4, valid4, gate4;
  logic [3:0]  unst4;

  int          n_err = 0;
  int          n_chk = 0;
  logic [15:0] exp_sig  [4];
  logic [15:0] prev_sig [4];
  logic        have_prev;
  int          exp_cnt;
  logic [3:0]  pat_a [32];
  logic [3:0]  pat_b [32];

  always #5 clk = ~clk;

  sigan_multi #(.CHANNELS(1)) dut1 (
    .clk        (clk),
    .reset_h    (reset_h),
    .sample_en_i(sample_en),
    .start_i    (start),
    .stop_i     (stop),
    .data_i     (data4[0:0]),
    .arm_i      (arm),
    .cont_i     (cont),
`ifdef SIGAN_HOLD_EN
    .hold_i     (hold),
`endif
    .signature_o(sig1),
    .bit_count_o(bcnt1),
    .count_ovf_o(ovf1),
    .unstable_o (unst1),
    .valid_o    (valid1),
    .gate_o     (gate1)
  );

  sigan_multi #(.CHANNELS(4), .CNT_W(4)) dut4 (
    .clk        (clk),
    .reset_h    (reset_h),
    .sample_en_i(sample_en),
    .start_i    (start),
    .stop_i     (stop),
    .data_i     (data4),
    .arm_i      (arm),
    .cont_i     (cont),
`ifdef SIGAN_HOLD_EN
    .hold_i     (hold),
`endif
    .signature_o(sig4),
    .bit_count_o(bcnt4),
    .count_ovf_o(ovf4),
    .unstable_o (unst4),
    .valid_o    (valid4),
    .gate_o     (gate4)
  );

  // Reference LFSR step for the default HP polynomial.
  function automatic logic [15:0] step(input logic [15:0] s, input logic d);
    return {s[14:0], d ^ (^(s & 16'h8940))};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one window (n shifted samples, each followed by an ignored non-sample cycle), ending with the stop sample.
  task automatic run_window(input int n, input logic [3:0] pat [32]);
    for (int c = 0; c < 4; c++) exp_sig[c] = '0;
    exp_cnt = n;
    sample_en = 1'b0; start = 1'b1; stop = 1'b1; data4 = 4'hF;
    tick();
    if (n == 0) begin
      sample_en = 1'b1; start = 1'b1; stop = 1'b1; data4 = 4'hF;
      tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        sample_en = 1'b1; start = (i == 0); stop = 1'b0; data4 = pat[i];
        tick();
        if (i == 0) check("gate_run", {gate1, gate4}, 2'b11);
        for (int c = 0; c < 4; c++) exp_sig[c] = step(exp_sig[c], pat[i][c]);
        sample_en = 1'b0; start = 1'b1; stop = 1'b1; data4 = ~pat[i];
        tick();
      end
      check("valid_before_stop", {valid1, valid4}, 2'b00);
      sample_en = 1'b1; start = 1'b0; stop = 1'b1; data4 = ~pat[n-1];
      tick();
    end
    sample_en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  // Compare both instances against the model right after the stop sample's edge.
  task automatic check_capture(input string tag);
    logic [3:0] exp_u;
    for (int c = 0; c < 4; c++) exp_u[c] = have_prev && (exp_sig[c] != prev_sig[c]);
    check({tag, "_valid"}, {valid1, valid4}, 2'b11);
    check({tag, "_sig1"}, sig1, exp_sig[0]);
    check({tag, "_sig4"}, sig4, {exp_sig[3], exp_sig[2], exp_sig[1], exp_sig[0]});
    check({tag, "_bcnt1"}, bcnt1, exp_cnt);
    check({tag, "_ovf1"}, ovf1, 1'b0);
    check({tag, "_bcnt4"}, bcnt4, (exp_cnt > 15) ? 15 : exp_cnt);
    check({tag, "_ovf4"}, ovf4, exp_cnt > 15);
    check({tag, "_unst1"}, unst1, exp_u[0]);
    check({tag, "_unst4"}, unst4, exp_u);
    check({tag, "_gate"}, {gate1, gate4}, 2'b00);
    for (int c = 0; c < 4; c++) prev_sig[c] = exp_sig[c];
    have_prev = 1'b1;
    tick();
    check({tag, "_valid_drop"}, {valid1, valid4}, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      pat_a[i] = {(i % 3) == 0, 1'b1, i[0], i == 0};
      pat_b[i] = pat_a[i];
    end
    pat_b[3] = pat_a[3] ^ 4'b0001;
    have_prev = 1'b0;
    reset_h = 1'b1; sample_en = 1'b0; start = 1'b0; stop = 1'b0;
    arm = 1'b0; cont = 1'b0; hold = 1'b0; data4 = 4'h0;
    tick();
    tick();
    check("rst_sig", {sig1, sig4}, 80'h0);
    check("rst_cnt", {bcnt1, bcnt4, ovf1, ovf4}, 30'h0);
    check("rst_flags", {unst1, unst4, valid1, valid4, gate1, gate4}, 9'h0);
    reset_h = 1'b0;
    tick();

    // Basic window: ch0 = 1 then seven 0s -> 16'h0081, 8 bits.
    cont = 1'b1; arm = 1'b1;
    tick();
    run_window(8, pat_a);
    check("w1_sig_const", sig1, 16'h0081);
    check("w1_cnt_const", bcnt1, 8);
    check_capture("w1");

    // Continuous re-arm: identical window, then one flipped ch0 bit.
    run_window(8, pat_a);
    check("w2_stable", {unst1, unst4}, 5'b0);
    check_capture("w2");
    run_window(8, pat_b);
    check("w3_unstable", {unst1, unst4}, 5'b1_0001);
    check_capture("w3");

    // Zero-length window: start and stop on the same sample.
    run_window(0, pat_a);
    check("w0_sig", {sig1, sig4}, 80'h0);
    check("w0_cnt", {bcnt1, bcnt4}, 28'h0);
    check_capture("w0");

    // Saturating counter on the 4-bit instance.
    run_window(20, pat_a);
    check("sat_cnt4", {bcnt4, ovf4}, 5'b1111_1);
    check("sat_cnt1", bcnt1, 20);
    check_capture("sat");

    // Asynchronous reset in the middle of a window.
    cont = 1'b0;
    tick();
    sample_en = 1'b1; start = 1'b1; data4 = 4'hF;
    tick();
    sample_en = 1'b0; start = 1'b0;
    tick();
    check("mid_gate", {gate1, gate4}, 2'b11);
    reset_h = 1'b1;
    #1;
    check("mid_rst_sig", {sig1, sig4}, 80'h0);
    check("mid_rst_flags", {bcnt1, bcnt4, ovf4, unst4, valid1, gate1, gate4}, 36'h0);
    tick();
    reset_h = 1'b0;
    have_prev = 1'b0;
    tick();
    check("post_rst_idle", {valid1, valid4, gate1, gate4}, 4'h0);
    run_window(8, pat_a);
    check("rerun_sig_const", sig1, 16'h0081);
    check_capture("rerun");

    // Single shot: DONE waits for arm=0 and never captures twice.
    tick();
    tick();
    check("single_no_recapture", {valid1, valid4, gate1, gate4}, 4'h0);
    arm = 1'b0;
    tick();

`ifdef SIGAN_HOLD_EN
    // Hold through DONE keeps the previous capture; next window captures again.
    cont = 1'b1; arm = 1'b1;
    tick();
    hold = 1'b1;
    run_window(5, pat_b);
    check("hold_no_valid", {valid1, valid4}, 2'b00);
    check("hold_keep_sig", sig1, 16'h0081);
    check("hold_keep_sig4", sig4, {prev_sig[3], prev_sig[2], prev_sig[1], prev_sig[0]});
    tick();
    hold = 1'b0;
    run_window(8, pat_b);
    check_capture("after_hold");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
